// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default TX FIFO depth and the byte type
// used by the transmitter, receiver and their buffers.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_TXF_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-write and transmitter-read handshakes of the UART TX FIFO.
// The slave view belongs to the FIFO; the master view drives it.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
);

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output wr_valid, wr_data, tx_ready,
        input  wr_ready, tx_valid, tx_data
    );

    modport slave (
        input  wr_valid, wr_data, tx_ready,
        output wr_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array with a synchronous write port and an
// asynchronous read port; shared by the TX and RX FIFOs.
module uart_fifo_mem #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] entries [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic              wr_en;
        logic [DATA_W-1:0] q;

        assign wr_en      = we && (waddr == AW'(i));
        assign entries[i] = q;

        // NOTE: only entry 0 is reset so the read port shows zero after reset;
        // the rest stay plain enable flops because their contents are unread until written.
        if (i == 0) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     q <= '0;
                else if (wr_en) q <= wdata;
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (wr_en) q <= wdata;
            end
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter: pointers, occupancy and sticky overflow.
// Define UART_TXF_ALMOST_FULL_EN to add the registered almost_full flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W   = UART_DATA_W,
    parameter  int DEPTH    = UART_TXF_DEPTH,
`ifdef UART_TXF_ALMOST_FULL_EN
    parameter  int AF_LEVEL = DEPTH - 2,
`endif
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus,
    output logic           overflow,
    input  logic           ovf_clr,
    output logic [AW:0]    count
`ifdef UART_TXF_ALMOST_FULL_EN
    ,
    output logic           almost_full
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          not_full;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          ovf_next;

    // Flags come from the registered count only, so a pop never opens a write in the same cycle.
    assign not_full     = (count != FULL_CNT);
    assign not_empty    = (count != '0);
    assign bus.wr_ready = not_full;
    assign bus.tx_valid = not_empty;

    assign push = bus.wr_valid && not_full;
    assign pop  = bus.tx_ready && not_empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // A rejected write outranks a clear arriving in the same cycle.
    assign ovf_next = (bus.wr_valid && !not_full) ? 1'b1 :
                      ovf_clr                     ? 1'b0 : overflow;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            overflow <= ovf_next;
        end
    end

`ifdef UART_TXF_ALMOST_FULL_EN
    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full <= 1'b0;
        else        almost_full <= (count_next >= AF_CNT);
    end
`endif

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (bus.tx_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table for the basic flow plus
// directed sequences for full/overflow, wrap-around, simultaneous ops and reset.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       overflow;
    logic       ovf_clr;
    logic [4:0] count;
`ifdef UART_TXF_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_if #(.DATA_W(8)) bus ();

    uart_tx_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .count    (count)
`ifdef UART_TXF_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       wv;
        uart_byte_t wd;
        logic       tr;
        logic       clr;
        logic [4:0] cnt;
        logic       tv;
        logic       wr;
        uart_byte_t td;
        logic       chk_td;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input uart_byte_t wd, input logic tr, input logic clr);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.tx_ready = tr;
        ovf_clr      = clr;
    endtask

    task automatic push_byte(input uart_byte_t d);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin : main
        uart_byte_t exp_q[$];
        uart_byte_t nxt;
        int         pushed;
        int         popped;
        int         cyc;
        logic       wv;
        logic       tr;

        //            wv  wd     tr  clr cnt  tv  wr  td     chk ovf
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 8'h43, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h43, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_count",    count,        0);
        check("rst_overflow", overflow,     0);
        check("rst_tx_data",  bus.tx_data,  0);
`ifdef UART_TXF_ALMOST_FULL_EN
        check("rst_almost_full", almost_full, 0);
`endif
        rst_n = 1'b1;
        tick();
        check("idle_count",    count,        0);
        check("idle_tx_valid", bus.tx_valid, 0);

        // Basic in-order write then single-cycle pops.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].tr, vecs[i].clr);
            tick();
            check($sformatf("vec%0d_count", i),    count,        vecs[i].cnt);
            check($sformatf("vec%0d_tx_valid", i), bus.tx_valid, vecs[i].tv);
            check($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vecs[i].wr);
            check($sformatf("vec%0d_overflow", i), overflow,     vecs[i].ovf);
            if (vecs[i].chk_td)
                check($sformatf("vec%0d_tx_data", i), bus.tx_data, vecs[i].td);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then write while full and clear.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("full_count",    count,        16);
        check("full_wr_ready", bus.wr_ready, 0);
        check("full_tx_data",  bus.tx_data,  8'h00);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        check("ovf_set",        overflow, 1);
        check("ovf_full_count", count,    16);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("ovf_cleared", overflow, 0);

        // Full with a pop and a write plus clear in the same cycle.
        drive(1'b1, 8'hBB, 1'b1, 1'b1);
        tick();
        check("fullpop_overflow", overflow,     1);
        check("fullpop_count",    count,        15);
        check("fullpop_wr_ready", bus.wr_ready, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("fullpop_ovf_clr", overflow, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_data_%0d", i), bus.tx_data, 8'(i));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("drain_count",    count,        0);
        check("drain_tx_valid", bus.tx_valid, 0);

        // Wrap-around: pushes every cycle, pops every other cycle.
        nxt    = 8'h50;
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 40 && cyc < 400) begin
            tr = cyc[0];
            wv = (pushed < 40) && bus.wr_ready;
            drive(wv, nxt, tr, 1'b0);
            check("wrap_tx_valid", bus.tx_valid, exp_q.size() != 0);
            if (bus.tx_valid && tr && exp_q.size() != 0) begin
                check("wrap_data", bus.tx_data, exp_q.pop_front());
                popped++;
            end
            if (wv) begin
                exp_q.push_back(nxt);
                nxt++;
                pushed++;
            end
            tick();
            check("wrap_count_le_16", count <= 5'd16, 1);
            check("wrap_count_model", count, exp_q.size());
            cyc++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap_popped",   popped,   40);
        check("wrap_overflow", overflow, 0);

        // Simultaneous push and pop at count 5.
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        check("sim_pre_count", count, 5);
        drive(1'b1, 8'h15, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("sim_count",   count,       5);
        check("sim_tx_data", bus.tx_data, 8'h11);

        // Reset mid-burst with count 9, checked before any clock edge.
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        check("burst_count", count, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count",    count,        0);
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_wr_ready", bus.wr_ready, 1);
        check("midrst_tx_data",  bus.tx_data,  0);
        #3;
        rst_n = 1'b1;
        tick();
        check("postrst_count", count, 0);

`ifdef UART_TXF_ALMOST_FULL_EN
        for (int i = 0; i < 13; i++) push_byte(8'(i));
        check("af_13", almost_full, 0);
        push_byte(8'h0D);
        check("af_14_count", count,       14);
        check("af_14",       almost_full, 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("af_drop_count", count,       13);
        check("af_drop",       almost_full, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer placed directly upstream of the UART transmit path.
- Accepts bytes from a host with a valid/ready write interface and stores up to DEPTH bytes.
- Presents the bytes in order on the transmitter's tx_valid / in / tx_ready handshake.
- Lets the host burst data while the serial line drains at baud rate, and reports loss and fill status.

Parameters:
- DATA_W, 8: byte width; must match the transmitter data width.
- DEPTH, 16: storage entries; power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  host presents a byte.
- wr_data  input  DATA_W  host byte.
- wr_ready  output  1  FIFO can accept (= not full).
- tx_valid  output  1  byte available to the transmitter (= not empty).
- tx_data  output  DATA_W  oldest stored byte; drives the transmitter data input.
- tx_ready  input  1  transmitter accepts the byte this cycle.
- overflow  output  1  sticky: a write was attempted while full.
- ovf_clr  input  1  synchronous clear of overflow.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: wr_ready=1, tx_valid=0.
  - tx_data=0, because storage entry 0 is cleared.
  - Any other storage contents are don't-care.
- Push: wr_valid && wr_ready at the clock edge.
  - mem[wr_ptr] <= wr_data; wr_ptr increments.
- Pop: tx_valid && tx_ready at the clock edge.
  - rd_ptr increments.
- Pointer wrap:
  - Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty are derived from count, not from pointer comparison.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - neither: unchanged.
- Full (count==DEPTH):
  - wr_ready=0.
  - A simultaneous pop does NOT open the write in that same cycle; wr_ready is a function of registered count only.
- Empty (count==0):
  - tx_valid=0; tx_ready is ignored.
  - A push into an empty FIFO shows tx_valid=1 on the following cycle (1-cycle write-to-read latency).
- tx_data:
  - Combinational read of mem[rd_ptr].
  - Stable while tx_valid=1 and no pop occurs; no data skipped or duplicated.
- Overflow:
  - Set when wr_valid=1 and wr_ready=0.
  - Stays set until an ovf_clr cycle.
  - If set and clear occur in the same cycle, set wins.
  - The rejected byte is dropped; storage is unchanged.
- Reset mid-operation:
  - All stored bytes are discarded immediately.
  - tx_valid drops asynchronously with rst_n.
  - The transmitter aborts its own frame on the same reset.
- No state machine beyond the pointer and count registers. The serial-side pacing comes entirely from tx_ready.

Optional Feature:
- Macro: UART_TXF_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2).
  - Adds output almost_full (1 bit) = registered (count >= AF_LEVEL).
  - almost_full updates on the same edge as count; reset value 0.
- When undefined:
  - No port and no logic.
  - Every other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - UART_TXF_DEPTH = 16 default.
  - Typedef for the byte type, reused by the transmitter and receiver.
- One natural sub-module: uart_fifo_mem.
  - DEPTH x DATA_W register array.
  - Synchronous write port, asynchronous read port.
  - Storage lives here so an RX-side FIFO can reuse it.
- Pointer, count and flag logic stay in uart_tx_fifo.

Test Plan:
- Reset then idle: after reset, wr_ready=1, tx_valid=0, count=0, overflow=0.
- Write 0x41, 0x42, 0x43 with tx_ready=0 -> count=3, tx_data=0x41. Then pulse tx_ready one cycle at a time -> 0x41, 0x42, 0x43 popped in order, then tx_valid=0.
- Fill 16 bytes 0x00..0x0F -> count=16, wr_ready=0. Write 0xAA while full -> overflow=1, and the data read back is still 0x00..0x0F. Assert ovf_clr -> overflow=0.
- Wrap-around: repeat 40 pushes of incrementing bytes while tx_ready toggles every other cycle -> output sequence equals the input sequence and count never exceeds 16.
- Simultaneous push/pop at count=5 -> count stays 5. At count=16 with tx_ready=1 and wr_valid=1 -> the write is rejected and overflow=1 on the following cycle, which exercises the full-plus-pop rule. With ovf_clr=1 in that same cycle -> overflow still sets.
- Reset mid-burst: with count=9, drop rst_n -> count=0 and tx_valid=0 without waiting for a clock edge. With the macro defined, almost_full goes to 1 when count reaches 14 and clears when count drops to 13.
